bram18_port_arbiter: RTL and testbench
======================================

# bram18_port_arbiter

Round-robin arbiter that shares one 18-bit-mode half-port (read/write) of the TDP36K block RAM among up to NUM_REQ requesters. It registers the winning command onto the RAM port and returns read data to the issuing requester after a fixed latency. It optionally zero-fills the RAM after reset before accepting traffic. It sits between client logic and one TDP36K port group (ADDR/WDATA/REN/WEN/BE/RDATA) in place of a direct inferred-memory connection.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 14, RAM port address width
- DATA_W, 18, RAM port data width
- BE_W, 2, byte-enable width
- CLEAR_ON_RESET, 1, 1 = zero-fill after reset; 0 = serve immediately
- CLEAR_DEPTH, 1024, number of addresses written during clear (0..CLEAR_DEPTH-1)
- CLK_i  in  1  single clock; all logic on rising edge
- RESET_N_i  in  1  reset, synchronous and active-low
- REQ_VALID_i  in  NUM_REQ  per-requester command valid
- REQ_READY_o  out  NUM_REQ  per-requester accept (one-hot or zero)
- REQ_WE_i  in  NUM_REQ  1 = write, 0 = read
- REQ_ADDR_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
- REQ_WDATA_i  in  NUM_REQ*DATA_W  packed write data
- REQ_BE_i  in  NUM_REQ*BE_W  packed byte enables
- RSP_VALID_o  out  NUM_REQ  one-hot read-data valid
- RSP_RDATA_o  out  DATA_W  shared read data, qualified by RSP_VALID_o
- RAM_ADDR_o  out  ADDR_W  to TDP36K ADDR
- RAM_WDATA_o  out  DATA_W  to TDP36K WDATA
- RAM_REN_o  out  1  to TDP36K REN
- RAM_WEN_o  out  1  to TDP36K WEN
- RAM_BE_o  out  BE_W  to TDP36K BE
- RAM_RDATA_i  in  DATA_W  from TDP36K RDATA; valid one cycle after REN
- CLEAR_DONE_o  out  1  high once clear is complete (constant high when CLEAR_ON_RESET=0)

## Operation
- FSM states: CLEAR, SERVE. After reset: CLEAR if CLEAR_ON_RESET=1, else SERVE.
- CLEAR: a counter runs 0..CLEAR_DEPTH-1, one write per cycle: WEN=1, BE all ones, WDATA=0, REN=0. After the write to CLEAR_DEPTH-1 the FSM moves to SERVE and sets CLEAR_DONE_o. REQ_READY_o stays 0 throughout CLEAR.
- SERVE arbitration: the grant is combinational from REQ_VALID_i and the round-robin pointer. The first valid requester at or after the pointer (modulo NUM_REQ) wins, and REQ_READY_o[winner]=1 in the same cycle. A handshake occurs when VALID and READY are both high.
- After each handshake the pointer becomes winner+1 (wraps NUM_REQ-1 -> 0). With no handshake the pointer holds.
- Accepted command is registered onto the RAM port next cycle: REN = ~WE, WEN = WE, plus ADDR, WDATA and BE. When no command is accepted, the next cycle drives REN=WEN=0; ADDR, WDATA and BE hold.
- Reads: the owner id is carried in a 2-stage valid/tag pipeline. RSP_VALID_o[owner] pulses for one cycle with RSP_RDATA_o = RAM_RDATA_i.
- Writes produce no response.
- Commands execute in grant order, so a read granted after a write to the same address returns the new data. No backpressure on responses; requesters must always sink them.

## Timing
- Reset values: REQ_READY_o=0, RSP_VALID_o=0, RSP_RDATA_o=0, RAM_REN_o=0, RAM_WEN_o=0, RAM_ADDR_o=0, RAM_WDATA_o=0, RAM_BE_o=0, CLEAR_DONE_o=0 (or 1 when CLEAR_ON_RESET=0). Pointer resets to 0 and the clear counter to 0.
- Handshake in cycle t -> RAM command in t+1 -> RSP_VALID_o in t+2 (read latency 2).
- Throughput is one command per cycle with no bubbles between back-to-back grants, including the same requester holding VALID.
- CLEAR takes exactly CLEAR_DEPTH cycles. CLEAR_DONE_o rises in the first SERVE cycle, and REQ_READY_o may assert in that same cycle.
- Reset asserted mid-clear: the counter restarts from 0 on the next clear.
- Reset asserted mid-traffic: in-flight responses are dropped, with no RSP_VALID_o after reset.
- REQ_VALID_i may drop without a handshake; the arbiter keeps no memory of it.

## Test plan
- Clear: CLEAR_DEPTH=16. Release reset -> 16 consecutive WEN cycles at addresses 0..15 with WDATA=0. CLEAR_DONE_o rises in cycle 17. A subsequent read of address 5 returns 0.
- Single requester: req1 writes 0x2ABCD to addr 0x0040, then reads 0x0040 back-to-back -> RAM WEN at t+1, REN at t+2; RSP_VALID_o=4'b0010 with data 0x2ABCD at t+3.
- Round robin: all 4 VALID held continuously from pointer 0 -> grants 0,1,2,3,0,1 on consecutive cycles; each read response is routed to the matching one-hot bit 2 cycles after its grant.
- Sparse contention: only req0 and req3 valid, pointer=1 -> req3 granted first, then req0, then req3.
- Reset mid-traffic: reads granted at t and t+1, RESET_N_i low at t+1 -> no RSP_VALID_o afterwards. All outputs read their reset values and the clear restarts from address 0.
- Byte enable: write 0x3FFFF with BE=2'b01, then read -> RAM_BE_o=2'b01 observed on the write cycle. The memory model returns the lower byte updated and the upper byte unchanged.

Source files
------------

// File: rtl/bram18_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// bram18_port_arbiter_if
// Bundles the requester-side command/response handshake and the TDP36K port
// group that bram18_port_arbiter sits between.
//
// Signal summary (names are from the arbiter's point of view):
//   REQ_VALID_i  [NUM_REQ]          per-requester command valid
//   REQ_READY_o  [NUM_REQ]          per-requester accept, one-hot or zero
//   REQ_WE_i     [NUM_REQ]          1 = write, 0 = read
//   REQ_ADDR_i   [NUM_REQ*ADDR_W]   packed addresses, requester k at k*ADDR_W
//   REQ_WDATA_i  [NUM_REQ*DATA_W]   packed write data
//   REQ_BE_i     [NUM_REQ*BE_W]     packed byte enables
//   RSP_VALID_o  [NUM_REQ]          one-hot read-data valid
//   RSP_RDATA_o  [DATA_W]           shared read data
//   RAM_ADDR_o / RAM_WDATA_o / RAM_REN_o / RAM_WEN_o / RAM_BE_o  to TDP36K
//   RAM_RDATA_i  [DATA_W]           from TDP36K, valid one cycle after REN
//
// Modports: slave = the arbiter, master = clients plus the RAM model.
// ----------------------------------------------------------------------------
interface bram18_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 18,
    parameter int BE_W    = 2
);
    logic [NUM_REQ-1:0]        REQ_VALID_i;
    logic [NUM_REQ-1:0]        REQ_READY_o;
    logic [NUM_REQ-1:0]        REQ_WE_i;
    logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR_i;
    logic [NUM_REQ*DATA_W-1:0] REQ_WDATA_i;
    logic [NUM_REQ*BE_W-1:0]   REQ_BE_i;
    logic [NUM_REQ-1:0]        RSP_VALID_o;
    logic [DATA_W-1:0]         RSP_RDATA_o;
    logic [ADDR_W-1:0]         RAM_ADDR_o;
    logic [DATA_W-1:0]         RAM_WDATA_o;
    logic                      RAM_REN_o;
    logic                      RAM_WEN_o;
    logic [BE_W-1:0]           RAM_BE_o;
    logic [DATA_W-1:0]         RAM_RDATA_i;

    modport slave (
        input  REQ_VALID_i, REQ_WE_i, REQ_ADDR_i, REQ_WDATA_i, REQ_BE_i, RAM_RDATA_i,
        output REQ_READY_o, RSP_VALID_o, RSP_RDATA_o,
        output RAM_ADDR_o, RAM_WDATA_o, RAM_REN_o, RAM_WEN_o, RAM_BE_o
    );

    modport master (
        output REQ_VALID_i, REQ_WE_i, REQ_ADDR_i, REQ_WDATA_i, REQ_BE_i, RAM_RDATA_i,
        input  REQ_READY_o, RSP_VALID_o, RSP_RDATA_o,
        input  RAM_ADDR_o, RAM_WDATA_o, RAM_REN_o, RAM_WEN_o, RAM_BE_o
    );
endinterface

// File: rtl/bram18_port_arbiter.sv
// ----------------------------------------------------------------------------
// bram18_port_arbiter
// Round-robin arbiter sharing one 18-bit-mode half-port of a TDP36K among
// NUM_REQ requesters. The winning command is registered onto the RAM port the
// cycle after its handshake, and read data is routed back to the issuing
// requester two cycles after the handshake. Optionally zero-fills addresses
// 0..CLEAR_DEPTH-1 after reset before any requester is accepted.
//
// Ports:
//   CLK_i         single rising-edge clock
//   RESET_N_i     synchronous active-low reset
//   io_bus        bram18_port_arbiter_if.slave: request/response handshake
//                 and the TDP36K ADDR/WDATA/REN/WEN/BE/RDATA group
//   CLEAR_DONE_o  high once the clear has finished (always high when
//                 CLEAR_ON_RESET = 0)
// ----------------------------------------------------------------------------
module bram18_port_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 18,
    parameter int BE_W           = 2,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CLEAR_DEPTH    = 1024
) (
    input  logic                 CLK_i,
    input  logic                 RESET_N_i,
    bram18_port_arbiter_if.slave io_bus,
    output logic                 CLEAR_DONE_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(CLEAR_DEPTH + 1);

    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CLR_END   = CNT_W'(CLEAR_DEPTH);

    localparam logic [0:0] ST_CLEAR   = 1'b0;
    localparam logic [0:0] ST_SERVE   = 1'b1;
    localparam logic [0:0] ST_RESET   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_SERVE;
    localparam logic       DONE_RESET = (CLEAR_ON_RESET == 0);

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   r_clrCnt;
    logic               r_clearDone;
    logic [PTR_W-1:0]   r_ptr;

    logic               r_ramRen;
    logic               r_ramWen;
    logic [ADDR_W-1:0]  r_ramAddr;
    logic [DATA_W-1:0]  r_ramWdata;
    logic [BE_W-1:0]    r_ramBe;

    logic               r_rdValid1;
    logic [PTR_W-1:0]   r_rdTag1;
    logic [NUM_REQ-1:0] r_rspValid;

    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    logic               w_serve;
    logic               w_handshake;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_winWe;
    logic [ADDR_W-1:0]  w_winAddr;
    logic [DATA_W-1:0]  w_winWdata;
    logic [BE_W-1:0]    w_winBe;

    // Scan the requesters starting at the round-robin pointer and wrapping
    // modulo NUM_REQ; the first valid one found wins. The wrap is done with a
    // compare-and-subtract so NUM_REQ need not be a power of two.
    always_comb begin
        logic [PTR_W:0] sum;
        sum      = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, r_ptr} + (PTR_W + 1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            if (!w_found && io_bus.REQ_VALID_i[sum[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = sum[PTR_W-1:0];
            end
        end
    end

    // Pull the winner's command fields out of the packed request buses.
    always_comb begin
        w_winWe    = 1'b0;
        w_winAddr  = '0;
        w_winWdata = '0;
        w_winBe    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (PTR_W'(k) == w_winner) begin
                w_winWe    = io_bus.REQ_WE_i[k];
                w_winAddr  = io_bus.REQ_ADDR_i[k*ADDR_W +: ADDR_W];
                w_winWdata = io_bus.REQ_WDATA_i[k*DATA_W +: DATA_W];
                w_winBe    = io_bus.REQ_BE_i[k*BE_W +: BE_W];
            end
        end
    end

    // READY only goes out while serving, so the winner's VALID is already
    // known high and a grant is the same thing as a handshake.
    always_comb begin
        w_serve     = (r_state == ST_SERVE);
        w_handshake = w_serve && w_found;
        w_grant     = '0;
        if (w_handshake) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    // Clear sequencing. The counter walks 0..CLEAR_DEPTH-1 issuing one write
    // per cycle; when it reaches CLEAR_DEPTH the last write is sitting on the
    // RAM port, so that cycle is used to hand over to SERVE. CLEAR_DONE_o and
    // the first possible READY therefore rise together, after every clear
    // write has been presented. A reset always restarts the counter at 0.
    always_ff @(posedge CLK_i) begin
        if (!RESET_N_i) begin
            r_state     <= ST_RESET;
            r_clrCnt    <= '0;
            r_clearDone <= DONE_RESET;
        end else if (r_state == ST_CLEAR) begin
            if (r_clrCnt == CLR_END) begin
                r_state     <= ST_SERVE;
                r_clearDone <= 1'b1;
            end else begin
                r_clrCnt <= r_clrCnt + 1'b1;
            end
        end
    end

    // Round-robin pointer: moves past the winner on every handshake and holds
    // otherwise, so a requester that drops VALID leaves no trace.
    always_ff @(posedge CLK_i) begin
        if (!RESET_N_i) begin
            r_ptr <= '0;
        end else if (w_handshake) begin
            r_ptr <= (w_winner == LAST_REQ) ? '0 : w_winner + 1'b1;
        end
    end

    // RAM port register. During clear it carries the zero-fill writes; while
    // serving it carries the command accepted in the previous cycle. Idle
    // cycles drop both strobes but keep address/data/BE so the port does not
    // toggle needlessly.
    always_ff @(posedge CLK_i) begin
        if (!RESET_N_i) begin
            r_ramRen   <= 1'b0;
            r_ramWen   <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
            r_ramBe    <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_ramRen <= 1'b0;
            if (r_clrCnt != CLR_END) begin
                r_ramWen   <= 1'b1;
                r_ramAddr  <= ADDR_W'(r_clrCnt);
                r_ramWdata <= '0;
                r_ramBe    <= '1;
            end else begin
                r_ramWen <= 1'b0;
            end
        end else if (w_handshake) begin
            r_ramRen   <= ~w_winWe;
            r_ramWen   <= w_winWe;
            r_ramAddr  <= w_winAddr;
            r_ramWdata <= w_winWdata;
            r_ramBe    <= w_winBe;
        end else begin
            r_ramRen <= 1'b0;
            r_ramWen <= 1'b0;
        end
    end

    // Two-stage owner pipeline for reads: stage 1 lines up with REN on the
    // RAM port, stage 2 lines up with RAM_RDATA_i and becomes the one-hot
    // response valid. Reset empties it so in-flight reads are dropped.
    always_ff @(posedge CLK_i) begin
        if (!RESET_N_i) begin
            r_rdValid1 <= 1'b0;
            r_rdTag1   <= '0;
            r_rspValid <= '0;
        end else begin
            r_rdValid1 <= w_handshake && !w_winWe;
            r_rdTag1   <= w_winner;
            r_rspValid <= '0;
            if (r_rdValid1) begin
                r_rspValid[r_rdTag1] <= 1'b1;
            end
        end
    end

    // Read data comes straight from the RAM; it is forced to zero whenever no
    // response is valid so the shared data bus is quiet in and after reset.
    assign io_bus.RSP_RDATA_o = (|r_rspValid) ? io_bus.RAM_RDATA_i : '0;
    assign io_bus.RSP_VALID_o = r_rspValid;
    assign io_bus.REQ_READY_o = w_grant;
    assign io_bus.RAM_REN_o   = r_ramRen;
    assign io_bus.RAM_WEN_o   = r_ramWen;
    assign io_bus.RAM_ADDR_o  = r_ramAddr;
    assign io_bus.RAM_WDATA_o = r_ramWdata;
    assign io_bus.RAM_BE_o    = r_ramBe;
    assign CLEAR_DONE_o       = r_clearDone;

endmodule

// File: tb/tb_bram18_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bram18_port_arbiter
// Self-checking bench for bram18_port_arbiter (4 requesters, 16-entry clear).
// A behavioural TDP36K model sits on the RAM side of the interface. Expected
// grants, RAM commands and responses come from a transaction-level reference:
// round-robin pointer as an integer, a shadow memory updated in grant order,
// and a queue of pending read responses with their due cycle.
// ----------------------------------------------------------------------------
module tb_bram18_port_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 14;
    localparam int DATA_W      = 18;
    localparam int BE_W        = 2;
    localparam int CLEAR_DEPTH = 16;
    localparam int LANE_W      = DATA_W / BE_W;
    localparam int MEM_DEPTH   = 1 << ADDR_W;

    typedef struct {
        int                due;
        int                tag;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic resetN;
    logic clearDone;

    int testCount = 0;
    int failCount = 0;

    bram18_port_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)
    ) bus ();

    bram18_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .CLEAR_ON_RESET(1), .CLEAR_DEPTH(CLEAR_DEPTH)
    ) dut (
        .CLK_i       (clk),
        .RESET_N_i   (resetN),
        .io_bus      (bus),
        .CLEAR_DONE_o(clearDone)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Fixed background pattern so untouched RAM words are never zero.
    function automatic logic [DATA_W-1:0] seedValue(input int a);
        return DATA_W'(a * 40503 + 341);
    endfunction

    // Byte-lane merge for the 18-bit mode: BE[b] covers bits b*9 +: 9.
    function automatic logic [DATA_W-1:0] mergeLanes(input logic [DATA_W-1:0] oldV,
                                                     input logic [DATA_W-1:0] newV,
                                                     input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] r;
        r = oldV;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[b*LANE_W +: LANE_W] = newV[b*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    // Behavioural TDP36K port: read data one cycle after REN, byte-masked
    // writes on WEN. Words never written read back the seed pattern.
    logic [DATA_W-1:0] envMem [MEM_DEPTH];
    bit                envWritten [MEM_DEPTH];
    logic [DATA_W-1:0] ramRdata = '0;

    function automatic logic [DATA_W-1:0] envRead(input logic [ADDR_W-1:0] a);
        return envWritten[a] ? envMem[a] : seedValue(int'(a));
    endfunction

    always @(posedge clk) begin
        if (bus.RAM_REN_o) ramRdata <= envRead(bus.RAM_ADDR_o);
        if (bus.RAM_WEN_o) begin
            envMem[bus.RAM_ADDR_o]     <= mergeLanes(envRead(bus.RAM_ADDR_o), bus.RAM_WDATA_o, bus.RAM_BE_o);
            envWritten[bus.RAM_ADDR_o] <= 1'b1;
        end
    end
    assign bus.RAM_RDATA_i = ramRdata;

    // Reference model state.
    logic [DATA_W-1:0] shadow [MEM_DEPTH];
    int                ptrModel;
    int                posCount;
    rsp_t              rspQ[$];
    logic              expRen, expWen;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expWdata;
    logic [BE_W-1:0]   expBe;

    // Stimulus state.
    logic [NUM_REQ-1:0] reqValid, reqWe;
    logic [ADDR_W-1:0]  reqAddr  [NUM_REQ];
    logic [DATA_W-1:0]  reqWdata [NUM_REQ];
    logic [BE_W-1:0]    reqBe    [NUM_REQ];

    // Observations used by directed checks.
    int                 lastGrant;
    logic [NUM_REQ-1:0] lastRspValid;
    logic [DATA_W-1:0]  lastRspData;

    int rrSeq [6] = '{0, 1, 2, 3, 0, 1};
    int spSeq [3] = '{3, 0, 3};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic driveBus();
        bus.REQ_VALID_i = reqValid;
        bus.REQ_WE_i    = reqWe;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.REQ_ADDR_i[k*ADDR_W +: ADDR_W]  = reqAddr[k];
            bus.REQ_WDATA_i[k*DATA_W +: DATA_W] = reqWdata[k];
            bus.REQ_BE_i[k*BE_W +: BE_W]        = reqBe[k];
        end
    endtask

    task automatic clearReqs();
        reqValid = '0;
        reqWe    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            reqAddr[k]  = '0;
            reqWdata[k] = '0;
            reqBe[k]    = '0;
        end
    endtask

    task automatic setReq(input int k, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        reqValid[k] = 1'b1;
        reqWe[k]    = we;
        reqAddr[k]  = a;
        reqWdata[k] = d;
        reqBe[k]    = be;
    endtask

    task automatic checkResetValues();
        checkOutput("rstReady",  bus.REQ_READY_o, 0);
        checkOutput("rstRspV",   bus.RSP_VALID_o, 0);
        checkOutput("rstRspD",   bus.RSP_RDATA_o, 0);
        checkOutput("rstRen",    bus.RAM_REN_o, 0);
        checkOutput("rstWen",    bus.RAM_WEN_o, 0);
        checkOutput("rstAddr",   bus.RAM_ADDR_o, 0);
        checkOutput("rstWdata",  bus.RAM_WDATA_o, 0);
        checkOutput("rstBe",     bus.RAM_BE_o, 0);
        checkOutput("rstDone",   clearDone, 0);
    endtask

    // One serving cycle: drive the requests, check the combinational grant,
    // advance the reference model on the clock edge, then check the RAM port
    // and the response bus half a cycle later.
    task automatic applyStimulus();
        int                 winner;
        logic [NUM_REQ-1:0] expReady;
        logic [NUM_REQ-1:0] expRsp;
        logic [DATA_W-1:0]  expData;
        rsp_t               r;

        driveBus();
        #1;
        winner = -1;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (winner < 0 && reqValid[(ptrModel + off) % NUM_REQ]) winner = (ptrModel + off) % NUM_REQ;
        end
        expReady = '0;
        if (winner >= 0) expReady[winner] = 1'b1;
        checkOutput("ready", bus.REQ_READY_o, expReady);
        lastGrant = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.REQ_READY_o[k]) lastGrant = k;
        end

        @(posedge clk);
        posCount++;
        if (winner >= 0) begin
            ptrModel = (winner + 1) % NUM_REQ;
            expRen   = !reqWe[winner];
            expWen   = reqWe[winner];
            expAddr  = reqAddr[winner];
            expWdata = reqWdata[winner];
            expBe    = reqBe[winner];
            if (reqWe[winner]) begin
                shadow[reqAddr[winner]] = mergeLanes(shadow[reqAddr[winner]], reqWdata[winner], reqBe[winner]);
            end else begin
                r.due  = posCount + 1;
                r.tag  = winner;
                r.data = shadow[reqAddr[winner]];
                rspQ.push_back(r);
            end
        end else begin
            expRen = 1'b0;
            expWen = 1'b0;
        end

        @(negedge clk);
        checkOutput("ramRen",   bus.RAM_REN_o, expRen);
        checkOutput("ramWen",   bus.RAM_WEN_o, expWen);
        checkOutput("ramAddr",  bus.RAM_ADDR_o, expAddr);
        checkOutput("ramWdata", bus.RAM_WDATA_o, expWdata);
        checkOutput("ramBe",    bus.RAM_BE_o, expBe);
        checkOutput("done",     clearDone, 1);
        expRsp  = '0;
        expData = '0;
        if (rspQ.size() > 0 && rspQ[0].due == posCount) begin
            r = rspQ.pop_front();
            expRsp[r.tag] = 1'b1;
            expData       = r.data;
        end
        checkOutput("rspValid", bus.RSP_VALID_o, expRsp);
        checkOutput("rspRdata", bus.RSP_RDATA_o, expData);
        if (|bus.RSP_VALID_o) begin
            lastRspValid = bus.RSP_VALID_o;
            lastRspData  = bus.RSP_RDATA_o;
        end
    endtask

    task automatic idleCycles(input int n);
        clearReqs();
        repeat (n) applyStimulus();
    endtask

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int a = 0; a < MEM_DEPTH; a++) shadow[a] = seedValue(a);
        ptrModel = 0;
        posCount = 0;

        // Reset, with every requester asking so READY=0 is meaningful.
        clearReqs();
        reqValid = '1;
        resetN   = 1'b0;
        driveBus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues();

        // Zero-fill: one write per cycle to 0..15, no READY, then done.
        resetN = 1'b1;
        for (int k = 0; k < CLEAR_DEPTH; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("clrWen",   bus.RAM_WEN_o, 1);
            checkOutput("clrRen",   bus.RAM_REN_o, 0);
            checkOutput("clrAddr",  bus.RAM_ADDR_o, k);
            checkOutput("clrWdata", bus.RAM_WDATA_o, 0);
            checkOutput("clrBe",    bus.RAM_BE_o, 2'b11);
            checkOutput("clrDone",  clearDone, 0);
            checkOutput("clrReady", bus.REQ_READY_o, 0);
        end
        clearReqs();
        driveBus();
        @(posedge clk);
        @(negedge clk);
        checkOutput("doneRise", clearDone, 1);
        checkOutput("doneWen",  bus.RAM_WEN_o, 0);
        checkOutput("doneRen",  bus.RAM_REN_o, 0);
        for (int a = 0; a < CLEAR_DEPTH; a++) shadow[a] = '0;
        expRen   = 1'b0;
        expWen   = 1'b0;
        expAddr  = ADDR_W'(CLEAR_DEPTH - 1);
        expWdata = '0;
        expBe    = '1;

        // Cleared word reads back zero.
        lastRspData = '1;
        clearReqs();
        setReq(2, 1'b0, 14'd5, '0, 2'b11);
        applyStimulus();
        idleCycles(2);
        checkOutput("clrRead5", lastRspData, 0);
        checkOutput("clrRead5V", lastRspValid, 4'b0100);

        // Single requester: write then read back-to-back.
        clearReqs();
        setReq(1, 1'b1, 14'h0040, 18'h2ABCD, 2'b11);
        applyStimulus();
        clearReqs();
        setReq(1, 1'b0, 14'h0040, '0, 2'b11);
        applyStimulus();
        idleCycles(2);
        checkOutput("wrRdData", lastRspData, 18'h2ABCD);
        checkOutput("wrRdV", lastRspValid, 4'b0010);

        // Bring the pointer back to 0, then hold all four VALIDs.
        clearReqs();
        setReq(3, 1'b0, 14'h0001, '0, 2'b11);
        applyStimulus();
        clearReqs();
        for (int k = 0; k < NUM_REQ; k++) setReq(k, 1'b0, ADDR_W'(16 + k), '0, 2'b11);
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("rrGrant", lastGrant, rrSeq[i]);
        end
        idleCycles(3);

        // Pointer to 1, then only req0 and req3 contend.
        clearReqs();
        setReq(0, 1'b1, 14'h0022, 18'h01234, 2'b11);
        applyStimulus();
        clearReqs();
        setReq(0, 1'b0, 14'h0022, '0, 2'b11);
        setReq(3, 1'b0, 14'h0040, '0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("spGrant", lastGrant, spSeq[i]);
        end
        idleCycles(3);

        // Byte enable: only the low lane of 0x2ABCD is overwritten.
        clearReqs();
        setReq(2, 1'b1, 14'h0040, 18'h3FFFF, 2'b01);
        applyStimulus();
        checkOutput("beOnPort", bus.RAM_BE_o, 2'b01);
        clearReqs();
        setReq(2, 1'b0, 14'h0040, '0, 2'b11);
        applyStimulus();
        idleCycles(2);
        checkOutput("beRdData", lastRspData, 18'h2ABFF);

        // Randomised traffic on a small address window to force collisions.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                reqValid[k] = 1'($urandom_range(0, 1));
                reqWe[k]    = 1'($urandom_range(0, 1));
                reqAddr[k]  = ADDR_W'($urandom_range(0, 31));
                reqWdata[k] = DATA_W'($urandom);
                reqBe[k]    = BE_W'($urandom_range(1, 3));
            end
            applyStimulus();
        end
        idleCycles(3);

        // Reset mid-traffic: reads granted at t and t+1, reset at t+1.
        clearReqs();
        setReq(0, 1'b0, 14'h0040, '0, 2'b11);
        applyStimulus();
        clearReqs();
        setReq(1, 1'b0, 14'h0041, '0, 2'b11);
        resetN = 1'b0;
        driveBus();
        @(posedge clk);
        @(negedge clk);
        checkResetValues();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rstNoRsp", bus.RSP_VALID_o, 0);
        end
        clearReqs();
        driveBus();
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("reclrWen",  bus.RAM_WEN_o, 1);
            checkOutput("reclrAddr", bus.RAM_ADDR_o, k);
            checkOutput("reclrRsp",  bus.RSP_VALID_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
